// File: rtl/boot_loader_arbiter.sv
// Bootloader and memory-port arbiter: streams a program image into the CPU memory,
// holds the CPU in reset through a settle window, then hands the memory port to it.
module boot_loader_arbiter #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int BASE_ADDR   = 0,
    parameter int HOLD_CYCLES = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_count,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic              mem_re,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [ADDR_W+1:0] MAX_COUNT = (ADDR_W+2)'((1 << ADDR_W) - BASE_ADDR);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_remaining;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_error;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_ptr_nxt;
    logic [ADDR_W:0]     w_remaining_nxt;
    logic [HOLD_W-1:0]   w_hold_cnt_nxt;
    logic                w_error_nxt;
    logic                w_accept;
    logic                w_count_legal;

    assign w_accept      = s_valid && s_ready;
    assign w_count_legal = ({1'b0, load_count} <= MAX_COUNT);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_ptr       <= ADDR_W'(BASE_ADDR);
            r_remaining <= '0;
            r_hold_cnt  <= '0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_remaining <= w_remaining_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_error     <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_remaining_nxt = r_remaining;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_error_nxt     = r_error;
        case (r_state)
            // IDLE and RUN share the start handling; an oversized image only flags error
            IDLE, RUN: begin
                if (start) begin
                    if (!w_count_legal) begin
                        w_error_nxt = 1'b1;
                    end else if (load_count == '0) begin
                        w_state_nxt    = HOLD;
                        w_hold_cnt_nxt = HOLD_W'(HOLD_CYCLES);
                    end else begin
                        w_state_nxt     = LOAD;
                        w_remaining_nxt = load_count;
                        w_ptr_nxt       = ADDR_W'(BASE_ADDR);
                    end
                end
            end
            LOAD: begin
                if (w_accept) begin
                    w_ptr_nxt       = r_ptr + 1'b1;
                    w_remaining_nxt = r_remaining - 1'b1;
                    if (r_remaining == (ADDR_W+1)'(1)) begin
                        w_state_nxt    = HOLD;
                        w_hold_cnt_nxt = HOLD_W'(HOLD_CYCLES);
                    end
                end
            end
            HOLD: begin
                w_hold_cnt_nxt = r_hold_cnt - 1'b1;
                if (r_hold_cnt == HOLD_W'(1)) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready   = 1'b0;
        mem_addr  = r_ptr;
        mem_din   = s_data;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        cpu_reset = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            LOAD: begin
                s_ready = 1'b1;
                mem_we  = s_valid;
                busy    = 1'b1;
            end
            HOLD: begin
                busy = 1'b1;
            end
            RUN: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
                mem_addr  = cpu_addr;
                mem_din   = cpu_wdata;
                mem_we    = cpu_we;
                mem_re    = cpu_re;
            end
            default: ;
        endcase
        // Reset forces safe outputs immediately, before the state register clears
        if (!reset) begin
            s_ready   = 1'b0;
            mem_we    = 1'b0;
            mem_re    = 1'b0;
            cpu_reset = 1'b1;
            busy      = 1'b0;
            done      = 1'b0;
        end
    end

    assign error = r_error;

endmodule
